// File: rtl/beacon_burst_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : beacon_burst_scheduler
//  Description : Plays the beacon ROM out as repeated bursts with an idle gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module beacon_burst_scheduler #(
    parameter int DEPTH = 40,
    parameter int AW    = 6,
    parameter int DW    = 24,
    parameter int GW    = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [7:0]    num_bursts,
    input  logic [GW-1:0] gap_cycles,
    output logic          rom_en,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] beacon_out,
    output logic          beacon_valid,
    output logic          busy,
    output logic          done,
    output logic [7:0]    burst_idx
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PLAY  = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [1:0]    r_state;
    logic          r_rom_en;
    logic [AW-1:0] r_rom_addr;
    logic [7:0]    r_burst_idx;
    logic [7:0]    r_num;
    logic [GW-1:0] r_gap;
    logic [GW-1:0] r_gap_cnt;
    logic          r_valid;
    logic          r_done;

    logic w_idle;
    logic w_accept;
    logic w_zero_req;
    logic w_abort;
    logic w_last_burst;

    assign w_idle       = (r_state == S_IDLE);
    assign w_accept     = w_idle && start && !abort && (num_bursts != 8'd0);
    assign w_zero_req   = w_idle && start && !abort && (num_bursts == 8'd0);
    assign w_abort      = abort && !w_idle;
    assign w_last_burst = (r_burst_idx == (r_num - 8'd1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_rom_en    <= 1'b0;
            r_rom_addr  <= '0;
            r_burst_idx <= 8'd0;
            r_num       <= 8'd0;
            r_gap       <= '0;
            r_gap_cnt   <= '0;
            r_valid     <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            // An abort discards the sample whose read is already in flight.
            r_valid <= r_rom_en && !w_abort;
            if (w_abort) begin
                r_state     <= S_IDLE;
                r_rom_en    <= 1'b0;
                r_rom_addr  <= '0;
                r_burst_idx <= 8'd0;
                r_gap_cnt   <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_num       <= num_bursts;
                            r_gap       <= gap_cycles;
                            r_rom_addr  <= '0;
                            r_burst_idx <= 8'd0;
                            r_rom_en    <= 1'b1;
                            r_state     <= S_PLAY;
                        end else if (w_zero_req) begin
                            r_done <= 1'b1;
                        end
                    end
                    S_PLAY: begin
                        if (r_rom_addr == LAST_ADDR) begin
                            r_rom_addr <= '0;
                            if (w_last_burst) begin
                                // done lines up with the final sample leaving the ROM
                                r_state  <= S_FLUSH;
                                r_rom_en <= 1'b0;
                                r_done   <= 1'b1;
                            end else begin
                                r_burst_idx <= r_burst_idx + 8'd1;
                                if (r_gap != '0) begin
                                    r_state   <= S_GAP;
                                    r_rom_en  <= 1'b0;
                                    r_gap_cnt <= r_gap;
                                end
                            end
                        end else begin
                            r_rom_addr <= r_rom_addr + AW'(1);
                        end
                    end
                    S_GAP: begin
                        r_gap_cnt <= r_gap_cnt - GW'(1);
                        if (r_gap_cnt == GW'(1)) begin
                            r_state  <= S_PLAY;
                            r_rom_en <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rom_en       = r_rom_en;
    assign rom_addr     = r_rom_addr;
    assign beacon_valid = r_valid;
    assign beacon_out   = r_valid ? rom_data : '0;
    assign busy         = !w_idle;
    assign done         = r_done;
    assign burst_idx    = r_burst_idx;

endmodule
`default_nettype wire

// File: tb/tb_beacon_burst_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_beacon_burst_scheduler
//  Description : Scoreboard bench; expected ROM reads, samples and done pulses
//                are scheduled by cycle number when each start is issued.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_beacon_burst_scheduler;

    localparam int DEPTH = 40;
    localparam int AW    = 6;
    localparam int DW    = 24;
    localparam int GW    = 16;

    logic          clk        = 1'b0;
    logic          rst_n      = 1'b0;
    logic          start      = 1'b0;
    logic          abort      = 1'b0;
    logic [7:0]    num_bursts = 8'd0;
    logic [GW-1:0] gap_cycles = '0;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data   = '0;
    logic [DW-1:0] beacon_out;
    logic          beacon_valid;
    logic          busy;
    logic          done;
    logic [7:0]    burst_idx;

    logic [DW-1:0] rom [DEPTH];

    typedef struct {
        int cyc;
        int addr;
        int burst;
        int data;
    } ev_t;

    ev_t rd_q[$];
    ev_t vq[$];
    int  dq[$];

    int errors    = 0;
    int checks    = 0;
    int cyc       = 0;
    int model_end = -1;
    int busy_from = 32'h3fff_ffff;
    int busy_to   = -1;

    beacon_burst_scheduler #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .GW(GW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .num_bursts  (num_bursts),
        .gap_cycles  (gap_cycles),
        .rom_en      (rom_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .beacon_out  (beacon_out),
        .beacon_valid(beacon_valid),
        .busy        (busy),
        .done        (done),
        .burst_idx   (burst_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rom_en) rom_data <= rom[rom_addr];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_ev(input string name, input int exp_cyc);
        checks++;
        errors++;
        $display("FAIL %s: at cycle %0d, expected event cycle %0d", name, cyc, exp_cyc);
    endtask

    // Monitor: pops and compares whenever the DUT presents a read, sample or done.
    always @(negedge clk) begin
        ev_t e;
        int  d;
        while (rd_q.size() > 0 && rd_q[0].cyc < cyc) begin
            fail_ev("rd_missing", rd_q[0].cyc);
            void'(rd_q.pop_front());
        end
        while (vq.size() > 0 && vq[0].cyc < cyc) begin
            fail_ev("valid_missing", vq[0].cyc);
            void'(vq.pop_front());
        end
        while (dq.size() > 0 && dq[0] < cyc) begin
            fail_ev("done_missing", dq[0]);
            void'(dq.pop_front());
        end
        if (rom_en) begin
            if (rd_q.size() == 0) fail_ev("rd_unexpected", -1);
            else begin
                e = rd_q.pop_front();
                chk("rd_cycle", cyc, e.cyc);
                chk("rd_addr", rom_addr, e.addr);
                chk("rd_burst_idx", burst_idx, e.burst);
            end
        end
        if (beacon_valid) begin
            if (vq.size() == 0) fail_ev("valid_unexpected", -1);
            else begin
                e = vq.pop_front();
                chk("valid_cycle", cyc, e.cyc);
                chk("beacon_data", beacon_out, e.data);
            end
        end else begin
            chk("beacon_out_zero", beacon_out, 0);
        end
        if (done) begin
            if (dq.size() == 0) fail_ev("done_unexpected", -1);
            else begin
                d = dq.pop_front();
                chk("done_cycle", cyc, d);
            end
        end
        chk("busy", busy, (cyc >= busy_from && cyc <= busy_to) ? 1 : 0);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drop every scheduled event at or after cycle 'from'.
    task automatic truncate(input int from);
        ev_t t[$];
        int  td[$];
        t = {};
        foreach (rd_q[j]) if (rd_q[j].cyc < from) t.push_back(rd_q[j]);
        rd_q = t;
        t = {};
        foreach (vq[j]) if (vq[j].cyc < from) t.push_back(vq[j]);
        vq = t;
        td = {};
        foreach (dq[j]) if (dq[j] < from) td.push_back(dq[j]);
        dq = td;
    endtask

    // Reference model: a burst sequence is N copies of ROM[0..DEPTH-1],
    // each separated by 'g' silent cycles; samples trail reads by one cycle.
    task automatic do_start(input int n, input int g);
        int k;
        int r0;
        int d;
        k          = cyc;
        start      = 1'b1;
        num_bursts = 8'(n);
        gap_cycles = GW'(g);
        if (!abort && k > model_end) begin
            if (n == 0) begin
                dq.push_back(k + 1);
            end else begin
                r0 = k + 1;
                for (int b = 0; b < n; b++) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        ev_t e;
                        e.cyc   = r0 + b * (DEPTH + g) + i;
                        e.addr  = i;
                        e.burst = b;
                        e.data  = int'(rom[i]);
                        rd_q.push_back(e);
                        e.cyc   = e.cyc + 1;
                        vq.push_back(e);
                    end
                end
                d = r0 + n * DEPTH + (n - 1) * g;
                dq.push_back(d);
                busy_from = k + 1;
                busy_to   = d;
                model_end = d;
            end
        end
        tick(1);
        start = 1'b0;
    endtask

    task automatic do_abort();
        int k;
        k     = cyc;
        abort = 1'b1;
        if (k <= model_end) begin
            truncate(k + 1);
            model_end = k;
            busy_to   = k;
        end
        tick(1);
        abort = 1'b0;
    endtask

    task automatic do_reset();
        int k;
        k = cyc;
        #1;
        rst_n = 1'b0;
        truncate(k);
        if (model_end >= k) model_end = k - 1;
        if (busy_to >= k) busy_to = k - 1;
        #1;
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_valid", beacon_valid, 0);
        chk("rst_beacon_out", beacon_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_burst_idx", burst_idx, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic wait_idle();
        while (cyc <= model_end + 1) tick(1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) rom[i] = DW'(i);
        #3;
        chk("reset_rom_en", rom_en, 0);
        chk("reset_valid", beacon_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_burst_idx", burst_idx, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick(2);

        // Single burst, then three bursts with gap, then back-to-back.
        do_start(1, 5); wait_idle(); tick(1);
        do_start(3, 4); wait_idle(); tick(1);
        do_start(2, 0); wait_idle(); tick(1);

        // Asynchronous reset in the middle of a burst (address 17).
        do_start(2, 3);
        tick(17);
        do_reset();
        tick(3);

        // Abort at burst 1 address 10, with an ignored start in between.
        do_start(3, 2);
        tick(5);
        do_start(5, 9);
        tick(46);
        do_abort();
        chk("abort_rom_en", rom_en, 0);
        chk("abort_burst_idx", burst_idx, 0);
        chk("abort_busy", busy, 0);
        tick(3);

        // Start coinciding with abort in idle is ignored.
        abort = 1'b1;
        do_start(2, 1);
        abort = 1'b0;
        tick(4);

        // Zero-burst request: done pulse only.
        do_start(0, 3);
        tick(3);

        // Randomised sequences with random ROM contents.
        for (int it = 0; it < 25; it++) begin
            int n;
            int g;
            int act;
            int len;
            wait_idle();
            for (int i = 0; i < DEPTH; i++) rom[i] = DW'($urandom);
            n   = $urandom_range(0, 3);
            g   = $urandom_range(0, 5);
            act = $urandom_range(0, 3);
            do_start(n, g);
            len = model_end - cyc;
            if (act == 0 && len > 0) begin
                tick($urandom_range(0, len));
                do_abort();
            end else if (act == 1 && len > 2) begin
                tick($urandom_range(0, len - 2));
                do_start($urandom_range(1, 4), $urandom_range(0, 5));
            end
            wait_idle();
            tick($urandom_range(0, 2));
        end

        tick(3);
        chk("queues_drained", rd_q.size() + vq.size() + dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
